// File: rtl/sva_pkg.sv
// Shared types for sampled-property checkers: control FSM states and attempt entries.
// No logic, no latency.
// No flow control; types only.
package sva_pkg;

    localparam int AGE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_LAUNCH = 2'd2
    } ctrl_state_t;

    // One live property attempt; age counts samples since its trigger.
    typedef struct packed {
        logic [AGE_W-1:0] age;
    } attempt_t;

endpackage

// File: rtl/sva_thread_ring.sv
// Circular buffer of live attempts, oldest at rd_ptr, newest just below wr_ptr.
// Combinational read at head+offset; push/pop/write-back take effect next cycle.
// No flow control; the caller never pushes when full nor pops when empty.
module sva_thread_ring
    import sva_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     clr,
    input  logic [$clog2(DEPTH)-1:0] rd_off,
    output attempt_t                 rd_entry,
    input  logic                     wb_en,
    input  attempt_t                 wb_entry,
    input  logic                     push_en,
    input  attempt_t                 push_entry,
    input  logic                     pop_en,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    attempt_t        mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_idx;

    assign rd_idx   = rd_ptr + rd_off;
    assign rd_entry = mem[rd_idx];

    // Storage carries no reset: only slots between rd_ptr and wr_ptr are meaningful.
    always_ff @(posedge sys_clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_entry;
        end else if (wb_en) begin
            mem[rd_idx] <= wb_entry;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sva_window_checker.sv
// Checks trig |-> ##[DLY_MIN:DLY_MAX] resp over sample_en strobes, with overlapping attempts.
// Latency: sample_en to busy low = live attempts + 2 cycles.
// Strobes arriving while busy are dropped and flagged on sample_miss.
module sva_window_checker
    import sva_pkg::*;
#(
    parameter int MAX_THREADS = 4,
    parameter int DLY_MIN     = 1,
    parameter int DLY_MAX     = 4,
    parameter int MATCH_ALL   = 1,
    parameter int CNT_W       = 16
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    input  logic                           clr,
    input  logic                           sample_en,
    input  logic                           trig,
    input  logic                           resp,
    output logic                           busy,
    output logic                           succ,
    output logic                           fail,
    output logic                           overflow,
    output logic                           sample_miss,
    output logic [$clog2(MAX_THREADS):0]   active_cnt,
    output logic [CNT_W-1:0]               succ_cnt,
    output logic [CNT_W-1:0]               fail_cnt
);

    localparam int PW = $clog2(MAX_THREADS);
    localparam int AW = PW + 1;
    localparam logic [AGE_W-1:0] MIN_AGE = AGE_W'(DLY_MIN);
    localparam logic [AGE_W-1:0] MAX_AGE = AGE_W'(DLY_MAX);
    localparam logic [AW-1:0]    FULL    = AW'(MAX_THREADS);

    ctrl_state_t      state;
    logic             trig_q;
    logic             resp_q;
    logic             consumed;
    logic [AW-1:0]    scan_len;
    logic [AW-1:0]    scan_idx;
    logic [PW-1:0]    keep_off;

    attempt_t         head;
    attempt_t         upd;
    attempt_t         new_att;
    logic [AGE_W-1:0] age_new;
    logic             scan_act;
    logic             in_win;
    logic             hit;
    logic             expire;
    logic             keep;
    logic             push_en;
    logic             last_step;

    // Retirements always form a prefix (older attempts are never younger in age),
    // so the next attempt to visit sits at head + number kept so far.
    always_comb begin
        upd       = '0;
        new_att   = '0;
        scan_act  = (state == ST_SCAN) && !clr;
        age_new   = head.age + AGE_W'(1);
        in_win    = (age_new >= MIN_AGE) && (age_new <= MAX_AGE);
        hit       = scan_act && resp_q && in_win && ((MATCH_ALL != 0) || !consumed);
        expire    = scan_act && !hit && (age_new >= MAX_AGE);
        keep      = scan_act && !hit && !expire;
        upd.age   = age_new;
        push_en   = (state == ST_LAUNCH) && !clr && trig_q && (active_cnt < FULL);
        last_step = (scan_idx == scan_len - AW'(1));
    end

    sva_thread_ring #(
        .DEPTH(MAX_THREADS)
    ) u_ring (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .clr       (clr),
        .rd_off    (keep_off),
        .rd_entry  (head),
        .wb_en     (keep),
        .wb_entry  (upd),
        .push_en   (push_en),
        .push_entry(new_att),
        .pop_en    (hit || expire),
        .count     (active_cnt)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            trig_q      <= 1'b0;
            resp_q      <= 1'b0;
            consumed    <= 1'b0;
            scan_len    <= '0;
            scan_idx    <= '0;
            keep_off    <= '0;
            busy        <= 1'b0;
            succ        <= 1'b0;
            fail        <= 1'b0;
            overflow    <= 1'b0;
            sample_miss <= 1'b0;
            succ_cnt    <= '0;
            fail_cnt    <= '0;
        end else if (clr) begin
            state       <= ST_IDLE;
            trig_q      <= 1'b0;
            resp_q      <= 1'b0;
            consumed    <= 1'b0;
            scan_len    <= '0;
            scan_idx    <= '0;
            keep_off    <= '0;
            busy        <= 1'b0;
            succ        <= 1'b0;
            fail        <= 1'b0;
            overflow    <= 1'b0;
            sample_miss <= 1'b0;
            succ_cnt    <= '0;
            fail_cnt    <= '0;
        end else begin
            succ        <= hit;
            fail        <= expire;
            overflow    <= 1'b0;
            sample_miss <= sample_en && busy;
            if (hit && !(&succ_cnt)) begin
                succ_cnt <= succ_cnt + CNT_W'(1);
            end
            if (expire && !(&fail_cnt)) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (sample_en) begin
                        trig_q   <= trig;
                        resp_q   <= resp;
                        scan_len <= active_cnt;
                        scan_idx <= '0;
                        keep_off <= '0;
                        consumed <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (active_cnt != '0) ? ST_SCAN : ST_LAUNCH;
                    end
                end
                ST_SCAN: begin
                    if (hit) begin
                        consumed <= 1'b1;
                    end
                    if (keep) begin
                        keep_off <= keep_off + PW'(1);
                    end
                    scan_idx <= scan_idx + AW'(1);
                    if (last_step) begin
                        state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (trig_q && (active_cnt >= FULL)) begin
                        overflow <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sva_window_checker.md
SVA_WINDOW_CHECKER -- requirements
Module: sva_window_checker

Interface
REQ-001 Parameter MAX_THREADS, default 4, is the maximum number of concurrent property attempts (power of two, 2..64).
REQ-002 Parameter DLY_MIN, default 1, is the earliest sample (>=1) after trigger at which resp satisfies an attempt.
REQ-003 Parameter DLY_MAX, default 4, is the last sample (>=DLY_MIN, <=255) at which resp satisfies an attempt.
REQ-004 Parameter MATCH_ALL, default 1: 1 = one resp sample completes every in-window attempt; 0 = it completes only the oldest in-window attempt.
REQ-005 Parameter CNT_W, default 16, is the width of the event counters.
REQ-006 sys_clk  in  1  single clock for all logic.
REQ-007 sys_rst  in  1  asynchronous, active-high reset.
REQ-008 clr  in  1  synchronous clear of attempts and counters.
REQ-009 sample_en  in  1  one-cycle strobe marking a user-clock sample point.
REQ-010 trig, resp  in  1 each  property antecedent and consequent, valid when sample_en=1.
REQ-011 busy  out  1  evaluation in progress.
REQ-012 succ, fail, overflow, sample_miss  out  1 each  one-cycle event pulses.
REQ-013 active_cnt  out  clog2(MAX_THREADS)+1  number of live attempts.
REQ-014 succ_cnt, fail_cnt  out  CNT_W each  saturating event totals.

Function
REQ-015 Property checked: trig |-> ##[DLY_MIN:DLY_MAX] resp, one attempt per sample with trig=1, overlapping attempts allowed.
REQ-016 Each attempt holds an age (samples since launch, 8 bits) in a circular buffer ordered oldest (rd pointer) to newest (wr pointer).
REQ-017 Control FSM states: IDLE, SCAN, LAUNCH; reset state IDLE.
REQ-018 IDLE: on sample_en, latch trig/resp, snapshot active_cnt as scan length; next state SCAN if length>0, else LAUNCH.
REQ-019 SCAN: one attempt per cycle, oldest first; age_new = age+1.
REQ-020 In SCAN: resp latched, DLY_MIN<=age_new<=DLY_MAX, and resp not yet consumed (MATCH_ALL=0 only) -> succ pulse, attempt retired.
REQ-021 Else if age_new>=DLY_MAX -> fail pulse, attempt retired; success takes precedence at age_new=DLY_MAX.
REQ-022 Otherwise age_new is written back in place.
REQ-023 Retired attempts always form a contiguous prefix from rd pointer; retirement advances rd pointer.
REQ-024 SCAN exits to LAUNCH after the last snapshot attempt.
REQ-025 LAUNCH: if trig latched and active_cnt<MAX_THREADS, write age 0 at wr pointer; if full, overflow pulse and attempt dropped; then IDLE.
REQ-026 busy=1 from the cycle after sample_en until LAUNCH completes; latency = scan length + 2 cycles (sample_en -> busy low).
REQ-027 sample_en while busy=1 is ignored and produces sample_miss pulse in the next cycle.
REQ-028 succ/fail may pulse on consecutive SCAN cycles; each pulse increments its counter by 1.
REQ-029 Counters saturate at all-ones and never wrap; pointers wrap modulo MAX_THREADS.
REQ-030 clr has priority over all: empties buffer, zeroes counters, returns to IDLE, suppresses pulses, mid-scan included.

Reset
REQ-031 sys_rst: FSM IDLE; pointers, active_cnt, succ_cnt, fail_cnt = 0; busy, succ, fail, overflow, sample_miss = 0.
REQ-032 Buffer contents need no reset; entries are valid only between rd and wr pointers.
REQ-033 Reset asserted mid-scan discards all attempts; no pulse emitted on release.

Structure
REQ-034 Package sva_pkg holds the ctrl FSM enum and the attempt-entry struct type (age field), shared with other checkers.
REQ-035 Sub-module sva_thread_ring implements the circular buffer (read head+offset, write-back, push, pop-prefix, count).

Verification
REQ-036 DLY_MIN=2, DLY_MAX=4: trig at sample 0, resp at sample 3 -> one succ, succ_cnt=1, active_cnt=0.
REQ-037 Same params: trig at sample 0, resp never -> fail at sample 4 scan, fail_cnt=1; resp at sample 1 -> no succ.
REQ-038 MATCH_ALL=1: trig at samples 0,1; resp at sample 3 -> two succ pulses on consecutive cycles; MATCH_ALL=0 -> one succ, second attempt fails at sample 5.
REQ-039 MAX_THREADS=4, DLY_MAX=8: trig on 5 consecutive samples -> overflow on the fifth, active_cnt stays 4.
REQ-040 sample_en repeated one cycle later while busy -> sample_miss pulse, attempt ages unchanged.
REQ-041 clr asserted during SCAN with 3 live attempts -> active_cnt=0, counters 0, busy low next cycle; sys_rst same mid-scan.
